// File: rtl/oneapi_stream_packet_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_REQ Avalon-ST sources onto one stream, with a 2-entry output buffer.
// Optional ARB_PKT_COUNT_EN adds per-source 16-bit completed-packet counters on port pkt_count.
module oneapi_stream_packet_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int BITS_AV    = 96,
    parameter int EMPTY_BITS = 4,
    parameter int ID_BITS    = 1
) (
    input  logic                          csi_clk,
    input  logic                          rsi_reset,
    input  logic [NUM_REQ-1:0]            asi_valid,
    output logic [NUM_REQ-1:0]            asi_ready,
    input  logic [NUM_REQ*BITS_AV-1:0]    asi_data,
    input  logic [NUM_REQ-1:0]            asi_startofpacket,
    input  logic [NUM_REQ-1:0]            asi_endofpacket,
    input  logic [NUM_REQ*EMPTY_BITS-1:0] asi_empty,
    output logic                          aso_valid,
    input  logic                          aso_ready,
    output logic [BITS_AV-1:0]            aso_data,
    output logic                          aso_startofpacket,
    output logic                          aso_endofpacket,
    output logic [EMPTY_BITS-1:0]         aso_empty,
    output logic [ID_BITS-1:0]            grant_id,
    output logic                          grant_active,
`ifdef ARB_PKT_COUNT_EN
    output logic [NUM_REQ-1:0]            orphan_err,
    output logic [NUM_REQ*16-1:0]         pkt_count
`else
    output logic [NUM_REQ-1:0]            orphan_err
`endif
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [ID_BITS-1:0]    last_ptr;
    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [BITS_AV-1:0]    buf_data [2];
    logic [1:0]            buf_sop;
    logic [1:0]            buf_eop;
    logic [EMPTY_BITS-1:0] buf_empty [2];

    logic [NUM_REQ-1:0]    cand;
    logic [NUM_REQ-1:0]    orphan;
    logic                  has_winner;
    logic [ID_BITS-1:0]    winner;
    logic [ID_BITS-1:0]    scan;
    logic                  push;
    logic                  pop;
    logic [BITS_AV-1:0]    in_data;
    logic                  in_sop;
    logic                  in_eop;
    logic [EMPTY_BITS-1:0] in_empty;

    // Scan from the farthest offset down so the nearest candidate after last_ptr wins.
    always_comb begin
        cand       = asi_valid & asi_startofpacket;
        has_winner = 1'b0;
        winner     = '0;
        scan       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan = ID_BITS'((int'(last_ptr) + k) % NUM_REQ);
            if (cand[scan]) begin
                has_winner = 1'b1;
                winner     = scan;
            end
        end
    end

    // Ungranted non-SOP beats are swallowed so a stray source cannot stall the arbiter.
    always_comb begin
        asi_ready = '0;
        orphan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == LOCKED && ID_BITS'(i) == grant_id) begin
                asi_ready[i] = (count < 2'd2);
            end else if (asi_valid[i] && !asi_startofpacket[i]) begin
                asi_ready[i] = 1'b1;
                orphan[i]    = 1'b1;
            end
        end
        if (rsi_reset) begin
            asi_ready = '0;
        end
    end

    assign in_data  = asi_data[int'(grant_id)*BITS_AV +: BITS_AV];
    assign in_sop   = asi_startofpacket[grant_id];
    assign in_eop   = asi_endofpacket[grant_id];
    assign in_empty = asi_empty[int'(grant_id)*EMPTY_BITS +: EMPTY_BITS];

    assign push = (state == LOCKED) && asi_valid[grant_id] && asi_ready[grant_id];
    assign pop  = (count != 2'd0) && aso_ready;

    assign aso_valid         = (count != 2'd0);
    assign aso_data          = buf_data[rd_ptr];
    assign aso_startofpacket = buf_sop[rd_ptr];
    assign aso_endofpacket   = buf_eop[rd_ptr];
    assign aso_empty         = buf_empty[rd_ptr];

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state        <= IDLE;
            grant_id     <= '0;
            grant_active <= 1'b0;
            last_ptr     <= ID_BITS'(NUM_REQ - 1);
            orphan_err   <= '0;
        end else begin
            orphan_err <= orphan_err | orphan;
            case (state)
                IDLE: begin
                    if (has_winner) begin
                        state        <= LOCKED;
                        grant_id     <= winner;
                        last_ptr     <= winner;
                        grant_active <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (push && in_eop) begin
                        state        <= IDLE;
                        grant_active <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push at full never happens because ready was derived from the registered count.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            count        <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            buf_data[0]  <= '0;
            buf_data[1]  <= '0;
            buf_sop      <= '0;
            buf_eop      <= '0;
            buf_empty[0] <= '0;
            buf_empty[1] <= '0;
        end else begin
            if (push) begin
                buf_data[wr_ptr]  <= in_data;
                buf_sop[wr_ptr]   <= in_sop;
                buf_eop[wr_ptr]   <= in_eop;
                buf_empty[wr_ptr] <= in_empty;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ARB_PKT_COUNT_EN
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            pkt_count <= '0;
        end else if (push && in_eop) begin
            pkt_count[int'(grant_id)*16 +: 16] <= pkt_count[int'(grant_id)*16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_oneapi_stream_packet_arbiter.sv
// Directed scoreboard bench for oneapi_stream_packet_arbiter (optionally with ARB_PKT_COUNT_EN).
module tb_oneapi_stream_packet_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int BITS_AV    = 96;
    localparam int EMPTY_BITS = 4;
    localparam int ID_BITS    = 1;

    logic                          csi_clk = 1'b0;
    logic                          rsi_reset;
    logic [NUM_REQ-1:0]            asi_valid;
    logic [NUM_REQ-1:0]            asi_ready;
    logic [NUM_REQ*BITS_AV-1:0]    asi_data;
    logic [NUM_REQ-1:0]            asi_startofpacket;
    logic [NUM_REQ-1:0]            asi_endofpacket;
    logic [NUM_REQ*EMPTY_BITS-1:0] asi_empty;
    logic                          aso_valid;
    logic                          aso_ready;
    logic [BITS_AV-1:0]            aso_data;
    logic                          aso_startofpacket;
    logic                          aso_endofpacket;
    logic [EMPTY_BITS-1:0]         aso_empty;
    logic [ID_BITS-1:0]            grant_id;
    logic                          grant_active;
    logic [NUM_REQ-1:0]            orphan_err;
`ifdef ARB_PKT_COUNT_EN
    logic [NUM_REQ*16-1:0]         pkt_count;
`endif

    oneapi_stream_packet_arbiter #(
        .NUM_REQ(NUM_REQ), .BITS_AV(BITS_AV), .EMPTY_BITS(EMPTY_BITS), .ID_BITS(ID_BITS)
    ) dut (
        .csi_clk(csi_clk),
        .rsi_reset(rsi_reset),
        .asi_valid(asi_valid),
        .asi_ready(asi_ready),
        .asi_data(asi_data),
        .asi_startofpacket(asi_startofpacket),
        .asi_endofpacket(asi_endofpacket),
        .asi_empty(asi_empty),
        .aso_valid(aso_valid),
        .aso_ready(aso_ready),
        .aso_data(aso_data),
        .aso_startofpacket(aso_startofpacket),
        .aso_endofpacket(aso_endofpacket),
        .aso_empty(aso_empty),
        .grant_id(grant_id),
        .grant_active(grant_active),
        .orphan_err(orphan_err)
`ifdef ARB_PKT_COUNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 csi_clk = ~csi_clk;

    typedef struct {
        logic [BITS_AV-1:0]    data;
        logic                  sop;
        logic                  eop;
        logic [EMPTY_BITS-1:0] empty;
        bit                    orphan;
        int                    start;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_lo = 0;
    int stall_hi = 0;
    bit hold_prev = 0;
    logic [BITS_AV+EMPTY_BITS+1:0] prev_out;
    int last_eop_cyc = -1;
    bit gap_check = 0;
    bit lat_check = 0;
    bit lat_seen = 0;
    int lat_expect = 0;
    bit grant_check = 0;
    int exp_cnt [2];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Queue one packet on a source; its beats are also the scoreboard's next expected output.
    function automatic void addPacket(int src, int nbeats, int tag, logic [EMPTY_BITS-1:0] last_empty, int start);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data   = {32'($urandom), 48'(tag), 16'(k + 17)};
            b.sop    = (k == 0);
            b.eop    = (k == nbeats - 1);
            b.empty  = b.eop ? last_empty : '0;
            b.orphan = 1'b0;
            b.start  = start;
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            exp_q.push_back(b);
        end
        exp_cnt[src]++;
    endfunction

    function automatic void addOrphan(int start);
        beat_t b;
        b.data   = {32'($urandom), 64'hDEAD_0000_0000_BEEF};
        b.sop    = 1'b0;
        b.eop    = 1'b0;
        b.empty  = '0;
        b.orphan = 1'b1;
        b.start  = start;
        q1.push_back(b);
    endfunction

    task automatic presentHeads();
        asi_valid         = '0;
        asi_startofpacket = '0;
        asi_endofpacket   = '0;
        if (q0.size() > 0 && cyc >= q0[0].start) begin
            asi_valid[0]                  = 1'b1;
            asi_data[0 +: BITS_AV]        = q0[0].data;
            asi_startofpacket[0]          = q0[0].sop;
            asi_endofpacket[0]            = q0[0].eop;
            asi_empty[0 +: EMPTY_BITS]    = q0[0].empty;
        end
        if (q1.size() > 0 && cyc >= q1[0].start) begin
            asi_valid[1]                        = 1'b1;
            asi_data[BITS_AV +: BITS_AV]        = q1[0].data;
            asi_startofpacket[1]                = q1[0].sop;
            asi_endofpacket[1]                  = q1[0].eop;
            asi_empty[EMPTY_BITS +: EMPTY_BITS] = q1[0].empty;
        end
        aso_ready = !(cyc >= stall_lo && cyc < stall_hi);
    endtask

    // One clock: observe at the falling edge, advance sources just after the rising edge.
    task automatic applyStimulus();
        logic acc0;
        logic acc1;
        beat_t e;
        logic [BITS_AV+EMPTY_BITS+1:0] cur;
        @(negedge csi_clk);
        acc0 = asi_valid[0] && asi_ready[0];
        acc1 = asi_valid[1] && asi_ready[1];
        if (asi_valid[1] && q1.size() > 0 && q1[0].orphan)
            checkOutput("orphan_ready", asi_ready[1], 1);
        cur = {aso_data, aso_startofpacket, aso_endofpacket, aso_empty};
        if (hold_prev) checkOutput("aso_stable", cur, prev_out);
        hold_prev = aso_valid && !aso_ready;
        prev_out  = cur;
        if (grant_check && grant_active) checkOutput("grant_id", grant_id, 0);
        if (lat_check && aso_valid && !lat_seen) begin
            lat_seen = 1'b1;
            checkOutput("first_latency", cyc, lat_expect);
        end
        if (stall_hi > stall_lo && cyc == stall_hi - 1) begin
            checkOutput("stall_src_ready", asi_ready[0], 0);
            checkOutput("stall_out_valid", aso_valid, 1);
        end
        if (aso_valid && aso_ready) begin
            checkOutput("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("beat", cur, {e.data, e.sop, e.eop, e.empty});
                if (gap_check && aso_startofpacket && last_eop_cyc >= 0)
                    checkOutput("packet_gap", cyc + 1 - last_eop_cyc, 2);
                if (aso_endofpacket) last_eop_cyc = cyc + 1;
            end
        end
        @(posedge csi_clk);
        cyc++;
        #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        presentHeads();
    endtask

    task automatic runTraffic(input int maxc);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            applyStimulus();
            n++;
        end
        checkOutput("traffic_done", (q0.size() + q1.size() + exp_q.size()) == 0, 1);
        repeat (2) applyStimulus();
    endtask

    task automatic doReset(input int ncyc);
        rsi_reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        hold_prev  = 1'b0;
        presentHeads();
        repeat (ncyc) begin
            @(posedge csi_clk);
            cyc++;
        end
        #1 rsi_reset = 1'b0;
        @(negedge csi_clk);
        checkOutput("rst_aso_valid", aso_valid, 0);
        checkOutput("rst_aso_data", aso_data, 0);
        checkOutput("rst_grant_active", grant_active, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_orphan_err", orphan_err, 0);
        checkOutput("rst_asi_ready", asi_ready, 0);
        @(posedge csi_clk);
        cyc++;
        #1;
        presentHeads();
    endtask

    initial begin
        rsi_reset         = 1'b1;
        asi_valid         = '0;
        asi_data          = '0;
        asi_startofpacket = '0;
        asi_endofpacket   = '0;
        asi_empty         = '0;
        aso_ready         = 1'b1;
        exp_cnt[0]        = 0;
        exp_cnt[1]        = 0;
        doReset(2);

        $display("[TB] single 3-beat packet from source 0");
        lat_check   = 1'b1;
        lat_seen    = 1'b0;
        lat_expect  = cyc + 2;
        grant_check = 1'b1;
        addPacket(0, 3, 0, 4'd4, cyc);
        presentHeads();
        runTraffic(50);
        checkOutput("latency_seen", lat_seen, 1);
        lat_check   = 1'b0;
        grant_check = 1'b0;

        $display("[TB] two sources contending, round-robin order");
        doReset(1);
        gap_check    = 1'b1;
        last_eop_cyc = -1;
        addPacket(0, 2, 'h20, 4'd0, cyc);
        addPacket(1, 3, 'h21, 4'd3, cyc);
        addPacket(0, 2, 'h22, 4'd1, cyc);
        addPacket(1, 1, 'h23, 4'd7, cyc);
        presentHeads();
        runTraffic(100);
        gap_check = 1'b0;
        checkOutput("rr_last_grant", grant_id, 1);
        checkOutput("idle_grant_active", grant_active, 0);

        $display("[TB] downstream stall mid-packet");
        addPacket(0, 8, 'h30, 4'd2, cyc);
        stall_lo = cyc + 3;
        stall_hi = cyc + 8;
        presentHeads();
        runTraffic(100);
        stall_lo = 0;
        stall_hi = 0;
        checkOutput("orphan_none", orphan_err, 0);

        $display("[TB] orphan beat from source 1 during source 0 packet");
        addPacket(0, 4, 'h40, 4'd5, cyc);
        addOrphan(cyc + 2);
        presentHeads();
        runTraffic(50);
        checkOutput("orphan_set", orphan_err, 2'b10);
        repeat (3) applyStimulus();
        checkOutput("orphan_sticky", orphan_err, 2'b10);

        $display("[TB] reset mid-packet then fresh arbitration");
        addPacket(0, 6, 'h50, 4'd0, cyc);
        presentHeads();
        repeat (4) applyStimulus();
        doReset(1);
        addPacket(0, 2, 'h60, 4'd1, cyc);
        addPacket(1, 1, 'h61, 4'd9, cyc);
        addPacket(0, 3, 'h62, 4'd0, cyc);
        addPacket(1, 2, 'h63, 4'd2, cyc);
        addPacket(0, 1, 'h64, 4'd3, cyc);
        addPacket(1, 3, 'h65, 4'd4, cyc);
        addPacket(0, 2, 'h66, 4'd6, cyc);
        presentHeads();
        runTraffic(200);
        $display("[TB] packets sent src0=%0d src1=%0d", exp_cnt[0], exp_cnt[1]);
`ifdef ARB_PKT_COUNT_EN
        checkOutput("pkt_count", pkt_count, {16'(exp_cnt[1]), 16'(exp_cnt[0])});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oneapi_stream_packet_arbiter.md
Name: oneapi_stream_packet_arbiter

Overview:
- Packet-aware round-robin arbiter sharing one Avalon-ST video path (input of the Avalon-to-AXI streaming gasket) between NUM_REQ Avalon-ST sources.
- Grant locks from startofpacket to endofpacket; beats never interleave.
- 2-entry output buffer decouples downstream backpressure from arbitration.
- Sits between the oneAPI kernel pipes and the gasket in the Platform Designer system.

Parameters:
- NUM_REQ, 2, number of requesting sources (2..4).
- BITS_AV, 96, Avalon data width (PARALLEL_PIXELS * CHANNELS * BITS_PER_CHANNEL_AV).
- EMPTY_BITS, 4, width of the empty field, clog2(BITS_AV/8).
- ID_BITS, 1, width of grant id, clog2(NUM_REQ).

Ports:
- csi_clk  in  1  clock
- rsi_reset  in  1  reset, synchronous, active-high
- asi_valid  in  NUM_REQ  per-source valid
- asi_ready  out  NUM_REQ  per-source ready
- asi_data  in  NUM_REQ*BITS_AV  packed data, source i at [i*BITS_AV +: BITS_AV]
- asi_startofpacket  in  NUM_REQ  per-source SOP
- asi_endofpacket  in  NUM_REQ  per-source EOP
- asi_empty  in  NUM_REQ*EMPTY_BITS  packed empty
- aso_valid  out  1  to gasket
- aso_ready  in  1  from gasket
- aso_data  out  BITS_AV  data
- aso_startofpacket  out  1  SOP
- aso_endofpacket  out  1  EOP
- aso_empty  out  EMPTY_BITS  empty
- grant_id  out  ID_BITS  current/last granted source
- grant_active  out  1  high in LOCKED
- orphan_err  out  NUM_REQ  sticky: non-SOP beat dropped from ungranted source

Behaviour:
- Reset (csi_clk edge with rsi_reset=1): state IDLE; buffer flushed; aso_valid=0, aso_sop/eop=0, aso_data=0, aso_empty=0; asi_ready=0; grant_id=0; grant_active=0; orphan_err=0; RR last-grant pointer=NUM_REQ-1 (source 0 highest priority first). Reset mid-packet abandons the packet; no EOP is emitted.
- FSM IDLE:
  - Candidates are sources with valid & SOP.
  - Winner = first candidate searching last+1, last+2 .. modulo NUM_REQ.
  - With a winner: next cycle LOCKED, grant_id=winner, pointer=winner, grant_active=1.
  - No beat is accepted from the winner in IDLE: 1-cycle arbitration bubble.
- FSM LOCKED:
  - asi_ready[grant_id] = buffer count<2 (count registered); other sources' ready=0, except for orphans (below).
  - An accepted beat (valid&ready) is written to the buffer.
  - Accepted beat with EOP -> IDLE the next cycle. Covers single-beat packets (SOP&EOP). grant_id holds its value; grant_active=0.
  - SOP on a granted non-first beat is forwarded unchanged; not policed.
- Orphan drop, any state: a source not currently granted presenting valid without SOP gets ready=1, the beat is discarded, and orphan_err[i] is set until reset. A source presenting valid&SOP is never dropped; it waits.
- Output buffer: 2-entry FIFO of {data, sop, eop, empty}.
  - aso_* driven from the head entry; aso_valid = count>0.
  - Pop on aso_valid&aso_ready.
  - Simultaneous push and pop keeps count unchanged, including at full (pop frees the slot; push is allowed only because ready was computed from the registered count<2, so no push occurs at count=2).
  - Latency: accepted input beat -> aso_valid 1 cycle later when the buffer was empty.
  - aso_* stable while aso_valid & !aso_ready.
- Throughput: 1 beat/cycle sustained in LOCKED with aso_ready=1; one bubble cycle per packet.
- Fields pass bit-exact; no width conversion. Empty is passed through unmodified.

Optional Feature:
- Macro ARB_PKT_COUNT_EN.
- When defined, adds output port pkt_count of width NUM_REQ*16: per-source 16-bit counter incremented on each accepted EOP beat of a granted packet. Counters wrap 0xFFFF->0 and are cleared by reset. Orphan beats are not counted.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Single source 0: 3-beat packet (data 0x..11/0x..12/0x..13, EOP beat empty=4), aso_ready=1 -> aso beats in order 2 cycles after SOP presented; empty=4 on EOP beat; grant_id=0.
- Both sources hold SOP from reset -> packet order src0, src1, src0, src1; no beat interleaving; exactly one bubble cycle between packets.
- aso_ready=0 for 5 cycles mid-packet -> buffer fills to 2; asi_ready[grant]=0; aso_* held constant; no beat lost or duplicated after release.
- Source 1 presents valid without SOP while source 0 is granted -> beat dropped, asi_ready[1]=1 that cycle, orphan_err=0b10 sticky; source 0 stream unaffected.
- rsi_reset=1 for 1 cycle mid-packet -> next cycle aso_valid=0, grant_active=0, orphan_err=0; next arbitration grants source 0 first.
- With ARB_PKT_COUNT_EN: 4 packets from src0 and 3 from src1, including one single-beat SOP&EOP -> pkt_count = {16'd3, 16'd4}.
